// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared widths and FSM encoding for the frequency calculator
package freq_pkg;

    localparam int CNT_W_DEF = 40;
    localparam int REF_W_DEF = 32;
    localparam int PW_DEF    = REF_W_DEF + CNT_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DIV     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/freq_calc_divider.sv
// rtl/freq_calc_divider.sv - restoring divider, one quotient bit per cycle, fixed PW-cycle latency
module seq_divider
    import freq_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int DW = CNT_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [PW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          done_o,
    output logic [PW-1:0] quotient_o,
    output logic [DW-1:0] remainder_o
);

    localparam int CW = $clog2(PW);

    logic [DW-1:0] rem_q, rem_d, rem_src;
    logic [DW-1:0] dvs_q, dvs_src;
    logic [PW-1:0] sh_q, sh_d, sh_src;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          done_q;
    logic [DW:0]   trial;
    logic          ge;

    // The start cycle already retires the first quotient bit, so done lands PW cycles after start.
    always_comb begin
        rem_src = start_i ? '0 : rem_q;
        sh_src  = start_i ? dividend_i : sh_q;
        dvs_src = start_i ? divisor_i : dvs_q;
        trial   = {rem_src, sh_src[PW-1]};
        ge      = (trial >= {1'b0, dvs_src});
        rem_d   = ge ? DW'(trial - {1'b0, dvs_src}) : trial[DW-1:0];
        sh_d    = {sh_src[PW-2:0], ge};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q <= rem_d;
                sh_q  <= sh_d;
                dvs_q <= divisor_i;
                cnt_q <= CW'(PW - 2);
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= rem_d;
                sh_q  <= sh_d;
                if (cnt_q == '0) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = sh_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/freq_calc.sv
// rtl/freq_calc.sv - computes F_REF*Nx/Ns after each gate window, in the reference clock domain
module freq_calc
    import freq_pkg::*;
#(
    parameter int              CNT_W  = CNT_W_DEF,
    parameter int              REF_W  = REF_W_DEF,
    parameter longint unsigned F_REF  = 100_000_000,
    parameter int              OUT_W  = 32,
    parameter int              SETTLE = 8
) (
    input  logic             reference,
    input  logic             rst_n,
    input  logic             gate,
    input  logic [CNT_W-1:0] Nx,
    input  logic [CNT_W-1:0] Ns,
    output logic [OUT_W-1:0] freq_hz,
    output logic             freq_valid,
    output logic             busy,
    output logic             err_div0,
    output logic             err_ovf,
    output logic             overrun
);

    localparam int              PW     = REF_W + CNT_W;
    localparam int              SW     = $clog2(SETTLE);
    localparam logic [REF_W-1:0] FREF_C = REF_W'(F_REF);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic             gate_s1_q, gate_s2_q, gate_hist_q;
    logic             gate_fall;
    state_e           state_q;
    logic [SW-1:0]    settle_q;
    logic [OUT_W-1:0] freq_hz_q;
    logic             freq_valid_q, busy_q, err_div0_q, err_ovf_q;
    logic [PW-1:0]    product;
    logic             div_start;
    logic             div_done;
    logic [PW-1:0]    div_quot;
    logic [CNT_W-1:0] div_rem_unused;

    always_ff @(posedge reference or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    always_ff @(posedge reference or negedge rst_int_n) begin
        if (!rst_int_n) begin
            gate_s1_q   <= 1'b0;
            gate_s2_q   <= 1'b0;
            gate_hist_q <= 1'b0;
        end else begin
            gate_s1_q   <= gate;
            gate_s2_q   <= gate_s1_q;
            gate_hist_q <= gate_s2_q;
        end
    end
    assign gate_fall = gate_hist_q & ~gate_s2_q;

    assign product   = PW'(FREF_C) * PW'(Nx);
    assign div_start = (state_q == ST_CAPTURE) && (Ns != '0);

    seq_divider #(
        .PW (PW),
        .DW (CNT_W)
    ) u_div (
        .clk_i       (reference),
        .rst_ni      (rst_int_n),
        .start_i     (div_start),
        .dividend_i  (product),
        .divisor_i   (Ns),
        .done_o      (div_done),
        .quotient_o  (div_quot),
        .remainder_o (div_rem_unused)
    );

    always_ff @(posedge reference or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            freq_hz_q    <= '0;
            freq_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_div0_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gate_fall) begin
                        state_q  <= ST_SETTLE;
                        settle_q <= SW'(SETTLE - 1);
                        busy_q   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0) state_q <= ST_CAPTURE;
                    else                settle_q <= settle_q - 1'b1;
                end
                ST_CAPTURE: begin
                    if (Ns == '0) begin
                        state_q      <= ST_DONE;
                        freq_valid_q <= 1'b1;
                        freq_hz_q    <= '1;
                        err_div0_q   <= 1'b1;
                        err_ovf_q    <= 1'b0;
                    end else begin
                        state_q <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_q      <= ST_DONE;
                        freq_valid_q <= 1'b1;
                        err_div0_q   <= 1'b0;
                        // Anything above OUT_W bits saturates the result.
                        if (div_quot[PW-1:OUT_W] != '0) begin
                            freq_hz_q <= '1;
                            err_ovf_q <= 1'b1;
                        end else begin
                            freq_hz_q <= div_quot[OUT_W-1:0];
                            err_ovf_q <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign overrun    = gate_fall & (state_q != ST_IDLE);
    assign freq_hz    = freq_hz_q;
    assign freq_valid = freq_valid_q;
    assign busy       = busy_q;
    assign err_div0   = err_div0_q;
    assign err_ovf    = err_ovf_q;

endmodule
